// File: rtl/mux41_pkg.sv
// Shared types and the rotating-priority pick function for the MUX41 round-robin arbiter.
package mux41_pkg;

  localparam int SEL_W = 2;
  localparam int NREQ  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Returns {found, idx}: first set bit of req scanning ptr, ptr+1, ... (mod NREQ).
  function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                             input logic [NREQ-1:0]  req);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker over four requesters.
module rr_pick4
  import mux41_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  req,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  assign {found, idx} = rr_pick(ptr, req);

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving the MUX41 selects; each grant is capped at MAX_BURST cycles.
module mux41_rr_arbiter
  import mux41_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [NREQ-1:0]  ireq,
  output logic [NREQ-1:0]  ogrant,
  output logic             os0,
  output logic             os1,
  output logic             ovalid,
  output logic [CNT_W-1:0] ocnt
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             release_now;

  // While granted, the scan starts just past the owner so a release re-arbitrates in-cycle.
  assign pick_ptr    = (state_reg == ST_GRANT) ? sel_reg + SEL_W'(1) : ptr_reg;
  assign release_now = !ireq[sel_reg] || (cnt_reg == CNT_W'(MAX_BURST));

  rr_pick4 u_pick (
    .ptr   (pick_ptr),
    .req   (ireq),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_GRANT;
          sel_next   = pick_idx;
          grant_next = NREQ'(1) << pick_idx;
          cnt_next   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_next = pick_ptr;
          if (pick_found) begin
            sel_next   = pick_idx;
            grant_next = NREQ'(1) << pick_idx;
            cnt_next   = CNT_W'(1);
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign ogrant = grant_reg;
  assign os0    = sel_reg[0];
  assign os1    = sel_reg[1];
  assign ovalid = (state_reg == ST_GRANT);
  assign ocnt   = cnt_reg;

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input, 4-bit mux datapath among four requesters.
- Registers a one-hot grant and drives the 2-bit mux select (os1, os0), which wires directly to MUX41 is1/is0.
- Bounds each grant to MAX_BURST cycles so no requester can starve the others.

Parameters:
- MAX_BURST, 4, maximum consecutive cycles one requester may hold the grant; legal range 1..15.
- CNT_W, 4, burst counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- iclk     input   1  clock; all state updates on rising edge.
- irst     input   1  reset, synchronous, active-high.
- ireq     input   4  request vector; bit n = requester n (mux input icn).
- ogrant   output  4  registered one-hot grant; all-zero when idle.
- os0      output  1  mux select LSB (to MUX41 is0).
- os1      output  1  mux select MSB (to MUX41 is1).
- ovalid   output  1  high while a grant is active; mux output oz is meaningful only when high.
- ocnt     output  CNT_W  cycles elapsed in the current grant (1..MAX_BURST); 0 when idle.

Behaviour:
- Reset (irst=1 at a clock edge): state=IDLE, ogrant=4'b0000, {os1,os0}=2'b00, ovalid=0, ocnt=0, priority pointer ptr=0.
- Reset overrides everything, including an active grant. The outputs are cleared on the edge irst is sampled high; no grant is issued that cycle.
- States: IDLE, GRANT.
- Arbitration function pick(ptr, req): the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4. Scan from ptr, not ptr+1.
- IDLE:
  - If ireq==0, stay in IDLE.
  - Otherwise g=pick(ptr, ireq). Next cycle: ogrant=onehot(g), {os1,os0}=g, ovalid=1, ocnt=1, state=GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT with current owner g; a release occurs when ireq[g]==0 or ocnt==MAX_BURST.
  - No release: hold grant and selects, ocnt<=ocnt+1.
  - Release: ptr<=(g+1) mod 4. Then arbitrate in the same cycle using the new ptr and the current ireq. Owner g may win again only if no other requester is pending.
    - If a winner h exists: grant h next cycle with ocnt=1 and no idle bubble.
    - If no requester is pending: IDLE next cycle, with ogrant=0, ovalid=0, ocnt=0. {os1,os0} holds its last value; it is don't-care while ovalid=0.
- Selects are always the binary encoding of the one-hot grant: ogrant=0001→00, 0010→01, 0100→10, 1000→11.
- ogrant is never multi-hot. ovalid==|ogrant at all times.
- Simultaneous events:
  - Owner drops its request on the same cycle ocnt hits MAX_BURST: a single release, handled as above.
  - Requests arriving mid-grant are not observed until the next release.
- ptr wraps 3→0. ocnt never exceeds MAX_BURST.
- No combinational path from ireq to any output; all outputs are registered.

Decomposition:
- Shared package mux41_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - SEL_W=2 and NREQ=4;
  - function rr_pick(ptr, req) returning {found, idx}.
- One natural sub-module: rr_pick4, combinational priority-rotate picker. It is instantiated once and used for both the IDLE and release-path arbitration.
- The top level contains the FSM, ptr, the counter and the output registers.

Test Plan:
- Reset and idle: assert irst for 2 cycles while ireq=4'b1111 → ogrant=0, ovalid=0, ocnt=0 throughout; after release, first grant=0001, {os1,os0}=00 one cycle later.
- Single requester with burst limit: ireq=4'b0100 held for 10 cycles, MAX_BURST=4 → grant 0100 with ocnt 1,2,3,4, then immediately re-granted with ocnt=1 and no ovalid gap; sel=10 throughout.
- Round-robin fairness: ireq=4'b1111 constant from reset → grant order 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, back-to-back.
- Early release and wrap: owner 3 (1000) drops ireq[3] at ocnt=2 while ireq=4'b0011 → next grant 0001 (ptr wrapped to 0), sel=00, ocnt=1.
- Drain to idle: a single owner drops its request with no others pending → next cycle ovalid=0, ogrant=0, ocnt=0. A new ireq=4'b0010 two cycles later → grant 0010 after 1 cycle.
- Reset mid-grant: irst pulsed while grant=0100 at ocnt=2 → outputs cleared on that edge, ptr=0; with ireq=4'b0101 after reset, next grant is 0001.
